flag_stack: RTL and testbench

FLAG_STACK -- requirements
Module: flag_stack

---
 rtl/flag_stack_pkg.sv | 36 +++
 rtl/flag_stack_mem.sv | 33 +++
 rtl/flag_stack.sv | 126 ++++++++++++
 tb/tb_flag_stack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/flag_stack_pkg.sv
// Shared definitions for the flag/context stack: ALU flag bit positions,
// stack entry field offsets, defaults and the push/pop request decode.
package flag_stack_pkg;

  localparam int DEPTH_DEFAULT = 16;

  // ALU flag bit indices inside the 4-bit {V,N,C,Z} flag word
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAGS_W = 4;

  // Entry layout {pc, flags[3:0], ie}, LSB first
  localparam int IE_OFS    = 0;
  localparam int FLAGS_OFS = 1;
  localparam int PC_OFS    = FLAGS_OFS + FLAGS_W;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_PUSH  = 2'd1,
    OP_POP   = 2'd2,
    OP_PROTO = 2'd3
  } op_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic proto;
  } err_t;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({pop, push});
  endfunction

endpackage

// File: rtl/flag_stack_mem.sv
// LIFO storage: DEPTH x W array, synchronous write, registered read.
// Only the read register is reset; the array itself is never cleared.
module flag_stack_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds the last popped entry until the next pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/flag_stack.sv
// Context stack for CALL/interrupt entry and RTS/RTI: saves {pc, flags, ie},
// restores them with one-cycle write strobes, and flags misuse stickily.
module flag_stack
  import flag_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PC_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     pop_rti,
  input  logic [PC_W-1:0]          pc_din,
  input  logic [FLAGS_W-1:0]       flags_din,
  input  logic                     ie_din,
  input  logic                     err_clr,
  output logic [PC_W-1:0]          pc_dout,
  output logic [FLAGS_W-1:0]       flag_dout,
  output logic                     flag_wr,
  output logic                     ie_dout,
  output logic                     ie_wr,
  output logic                     pc_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf_err,
  output logic                     unf_err,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_OFS + PC_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count_q, count_d;
  err_t          err_q, err_d, err_set;
  logic          pc_valid_q, rti_wr_q;
  logic          do_push, do_pop;
  op_e           op;
  logic [CW-1:0] rd_ptr;
  logic [EW-1:0] wr_entry, rd_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign op    = decode_op(push, pop);

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = '0;
    count_d = count_q;
    unique case (op)
      OP_PUSH: begin
        if (full) err_set.ovf = 1'b1;
        else begin
          do_push = 1'b1;
          count_d = count_q + ONE;
        end
      end
      OP_POP: begin
        if (empty) err_set.unf = 1'b1;
        else begin
          do_pop  = 1'b1;
          count_d = count_q - ONE;
        end
      end
      OP_PROTO: err_set.proto = 1'b1;
      default: ;
    endcase
    // A new error in the same cycle as err_clr survives the clear
    err_d = err_set | (err_clr ? err_t'('0) : err_q);
  end

  always_comb begin
    wr_entry = '0;
    wr_entry[IE_OFS]              = ie_din;
    wr_entry[FLAGS_OFS +: FLAGS_W] = flags_din;
    wr_entry[PC_OFS +: PC_W]      = pc_din;
  end

  assign rd_ptr = count_q - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      err_q      <= '0;
      pc_valid_q <= 1'b0;
      rti_wr_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      err_q      <= err_d;
      pc_valid_q <= do_pop;
      rti_wr_q   <= do_pop & pop_rti;
    end
  end

  flag_stack_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_push),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_entry),
    .re    (do_pop),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  assign pc_dout   = rd_entry[PC_OFS +: PC_W];
  assign flag_dout = rd_entry[FLAGS_OFS +: FLAGS_W];
  assign ie_dout   = rd_entry[IE_OFS];
  assign pc_valid  = pc_valid_q;
  assign flag_wr   = rti_wr_q;
  assign ie_wr     = rti_wr_q;
  assign count     = count_q;
  assign ovf_err   = err_q.ovf;
  assign unf_err   = err_q.unf;
  assign proto_err = err_q.proto;

endmodule

// File: tb/tb_flag_stack.sv
// Bench for flag_stack: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the context stack.
module tb_flag_stack;
  import flag_stack_pkg::*;

  localparam int DEPTH = 16;
  localparam int PC_W  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            push = 1'b0, pop = 1'b0, pop_rti = 1'b0, err_clr = 1'b0;
  logic [PC_W-1:0] pc_din = '0;
  logic [3:0]      flags_din = '0;
  logic            ie_din = 1'b0;
  logic [PC_W-1:0] pc_dout;
  logic [3:0]      flag_dout;
  logic            flag_wr, ie_dout, ie_wr, pc_valid, empty, full;
  logic [CW-1:0]   count;
  logic            ovf_err, unf_err, proto_err;

  flag_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pop_rti(pop_rti),
    .pc_din(pc_din), .flags_din(flags_din), .ie_din(ie_din), .err_clr(err_clr),
    .pc_dout(pc_dout), .flag_dout(flag_dout), .flag_wr(flag_wr),
    .ie_dout(ie_dout), .ie_wr(ie_wr), .pc_valid(pc_valid), .count(count),
    .empty(empty), .full(full), .ovf_err(ovf_err), .unf_err(unf_err),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [3:0]      fl;
    logic            ie;
  } ent_t;

  ent_t            stk[$];
  logic [PC_W-1:0] m_pc;
  logic [3:0]      m_fl;
  logic            m_ie, m_pv, m_rti, m_ovf, m_unf, m_pro;
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_pc = '0; m_fl = '0; m_ie = 0; m_pv = 0; m_rti = 0;
    m_ovf = 0; m_unf = 0; m_pro = 0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic rti,
                            input logic [PC_W-1:0] pc, input logic [3:0] fl,
                            input logic ie, input logic clr);
    ent_t e;
    m_pv = 0; m_rti = 0;
    if (clr) begin m_ovf = 0; m_unf = 0; m_pro = 0; end
    if (p && q) m_pro = 1;
    else if (p) begin
      if (stk.size() == DEPTH) m_ovf = 1;
      else begin e.pc = pc; e.fl = fl; e.ie = ie; stk.push_back(e); end
    end else if (q) begin
      if (stk.size() == 0) m_unf = 1;
      else begin
        e = stk.pop_back();
        m_pc = e.pc; m_fl = e.fl; m_ie = e.ie; m_pv = 1; m_rti = rti;
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(stk.size()));
    chk("empty", 32'(empty), 32'(stk.size() == 0));
    chk("full", 32'(full), 32'(stk.size() == DEPTH));
    chk("pc_valid", 32'(pc_valid), 32'(m_pv));
    chk("flag_wr", 32'(flag_wr), 32'(m_rti));
    chk("ie_wr", 32'(ie_wr), 32'(m_rti));
    chk("pc_dout", 32'(pc_dout), 32'(m_pc));
    chk("flag_dout", 32'(flag_dout), 32'(m_fl));
    chk("ie_dout", 32'(ie_dout), 32'(m_ie));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("unf_err", 32'(unf_err), 32'(m_unf));
    chk("proto_err", 32'(proto_err), 32'(m_pro));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare everything
  task automatic cycle(input logic p, input logic q, input logic rti,
                       input logic [PC_W-1:0] pc, input logic [3:0] fl,
                       input logic ie, input logic clr);
    push = p; pop = q; pop_rti = rti; pc_din = pc; flags_din = fl;
    ie_din = ie; err_clr = clr;
    @(posedge clk);
    #1;
    push = 0; pop = 0; pop_rti = 0; err_clr = 0;
    model_step(p, q, rti, pc, fl, ie, clr);
    check_all();
  endtask

  task automatic do_push(input logic [PC_W-1:0] pc, input logic [3:0] fl, input logic ie);
    cycle(1, 0, 0, pc, fl, ie, 0);
  endtask

  task automatic do_pop(input logic rti);
    cycle(0, 1, rti, '0, '0, 0, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    logic [3:0] fl_vc;
    int r;
    fl_vc = '0;
    fl_vc[FLAG_V] = 1'b1;
    fl_vc[FLAG_C] = 1'b1;

    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Push then RTI restores everything with all strobes for one cycle
    do_push(8'h3A, fl_vc, 1);
    do_pop(1);
    chk("rti_pc", 32'(pc_dout), 32'h3A);
    chk("rti_flags", 32'(flag_dout), 32'b1010);
    chk("rti_strobes", 32'({flag_wr, ie_wr, pc_valid, ie_dout}), 32'b1111);
    idle();
    chk("rti_hold", 32'({pc_valid, flag_wr, pc_dout}), 32'h03A);

    // RTS pops in LIFO order without flag writes
    do_push(8'h10, 4'h1, 0);
    do_push(8'h20, 4'h2, 1);
    do_pop(0);
    chk("rts_first", 32'(pc_dout), 32'h20);
    do_pop(0);
    chk("rts_second", 32'(pc_dout), 32'h10);
    chk("rts_empty", 32'(empty), 32'h1);

    // Push right after a pop reuses the freed slot
    do_push(8'h51, 4'h5, 1);
    do_push(8'h52, 4'h6, 0);
    do_pop(1);
    do_push(8'h53, 4'h7, 1);
    do_pop(0);
    chk("reuse_slot", 32'(pc_dout), 32'h53);
    do_pop(1);
    chk("reuse_bottom", 32'(pc_dout), 32'h51);

    // Fill to DEPTH, overflow, then drain in reverse
    for (int i = 0; i < DEPTH; i++) do_push(PC_W'(8'h80 + i), 4'(i), i[0]);
    do_push(8'hFF, 4'hF, 1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag", 32'(ovf_err), 32'h1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      do_pop(i[1]);
      chk("drain_pc", 32'(pc_dout), 32'(8'h80 + i));
    end

    // Underflow, then clear on the following cycle
    do_pop(1);
    chk("unf_flag", 32'({unf_err, pc_valid, flag_wr}), 32'b100);
    cycle(0, 0, 0, '0, '0, 0, 1);
    chk("unf_clr", 32'({ovf_err, unf_err}), 32'h0);

    // Set beats clear in the same cycle
    cycle(0, 1, 0, '0, '0, 0, 1);
    chk("set_wins", 32'(unf_err), 32'h1);
    cycle(0, 0, 0, '0, '0, 0, 1);

    // Simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) do_push(PC_W'(8'h40 + i), 4'(i), 0);
    cycle(1, 1, 1, 8'h99, 4'h9, 1, 0);
    chk("proto_count", 32'(count), 32'h3);
    chk("proto_flag", 32'({proto_err, pc_valid, flag_wr}), 32'b100);
    do_pop(0);
    chk("proto_top", 32'(pc_dout), 32'h42);

    // Asynchronous reset mid-cycle discards contents and a pending strobe
    do_push(8'h61, 4'h3, 1);
    do_push(8'h62, 4'h4, 0);
    do_pop(1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      cycle(r < 45 || (r >= 92 && r < 95),
            (r >= 45 && r < 88) || (r >= 92 && r < 95),
            1'($urandom_range(0, 1)),
            PC_W'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
